// File: rtl/opll_write_sequencer.sv
// OPLL chip-bus write sequencer: a 4-deep {addr,data} request FIFO feeding a
// tick-paced address/data strobe engine with post-write idle waits.
module opll_write_sequencer #(
  parameter int unsigned STROBE_W  = 2,
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_REQ_VALID,
  input  logic [7:0] i_REQ_ADDR,
  input  logic [7:0] i_REQ_DATA,
  output logic       o_REQ_READY,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_D_OE,
  output logic       o_BUSY
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  // Counters run down to zero, so a wait of 0 still costs one tick.
  localparam logic [7:0] L_STROBE_LD = 8'(STROBE_W - 1);
  localparam logic [7:0] L_AWAIT_LD  = (ADDR_WAIT == 0) ? 8'd0 : 8'(ADDR_WAIT - 1);
  localparam logic [7:0] L_DWAIT_LD  = (DATA_WAIT == 0) ? 8'd0 : 8'(DATA_WAIT - 1);

  logic [15:0] r_mem [4];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_count;

  logic [2:0]  r_state;
  logic        r_phase;
  logic [7:0]  r_cnt;
  logic [7:0]  r_data;
  logic        r_cs_n, r_wr_n, r_a0, r_d_oe;
  logic [7:0]  r_d;

  logic        w_tick, w_push, w_pop, w_nonempty;
  logic [15:0] w_head;

  assign w_tick      = ~i_phiM_PCEN_n;
  assign w_nonempty  = (r_count != 3'd0);
  assign o_REQ_READY = (r_count != 3'd4);
  assign w_push      = i_REQ_VALID & o_REQ_READY;
  assign w_pop       = w_tick & (r_state == ST_IDLE) & w_nonempty;
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge i_EMUCLK) begin
    if (w_push) r_mem[r_wptr] <= {i_REQ_ADDR, i_REQ_DATA};
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bus outputs only change on ticks and A0/D only move while CS_n is high.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
      r_cnt   <= 8'd0;
      r_data  <= 8'd0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_a0    <= 1'b0;
      r_d     <= 8'd0;
      r_d_oe  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_nonempty) begin
            r_state <= ST_SETUP;
            r_phase <= 1'b0;
            r_a0    <= 1'b0;
            r_d     <= w_head[15:8];
            r_data  <= w_head[7:0];
            r_d_oe  <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_cs_n  <= 1'b0;
          r_wr_n  <= 1'b0;
          r_cnt   <= L_STROBE_LD;
        end
        ST_STROBE: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_HOLD;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          r_state <= ST_WAIT;
          r_d_oe  <= 1'b0;
          r_d     <= 8'd0;
          r_cnt   <= r_phase ? L_DWAIT_LD : L_AWAIT_LD;
        end
        ST_WAIT: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!r_phase) begin
            r_state <= ST_SETUP;
            r_phase <= 1'b1;
            r_a0    <= 1'b1;
            r_d     <= r_data;
            r_d_oe  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
            r_a0    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_CS_n = r_cs_n;
  assign o_WR_n = r_wr_n;
  assign o_A0   = r_a0;
  assign o_D    = r_d;
  assign o_D_OE = r_d_oe;
  assign o_BUSY = w_nonempty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Scoreboard bench: accepted requests queue their expected {A0,D} strobes;
// a monitor pops and checks each CS_n low window as it appears.
module tb_opll_write_sequencer;

  localparam int unsigned STROBE_W  = 2;
  localparam int unsigned ADDR_WAIT = 12;
  localparam int unsigned DATA_WAIT = 84;
  localparam int unsigned PAIR_TICKS = 2 * (STROBE_W + 2) + ADDR_WAIT + DATA_WAIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n;
  logic       valid = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       ready, cs_n, wr_n, a0, d_oe, busy;
  logic [7:0] d;

  logic       valid2 = 1'b0;
  logic [7:0] addr2 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       ready2, cs2_n, wr2_n, a0_2, d_oe2, busy2;
  logic [7:0] d2;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned ticks = 0;
  int unsigned cyc = 0;
  bit          hold = 1'b0;
  bit          abort_ok = 1'b0;
  logic [8:0]  exp_q [$];

  logic        m_prev_cs = 1'b1;
  int unsigned m_st_tick = 0;
  int unsigned m_addr_tick = 0;
  logic [8:0]  m_cur = 9'd0;
  logic [8:0]  m_exp = 9'd0;
  bit          m_stable = 1'b1;

  logic        m2_prev_cs = 1'b1;
  logic        m2_a0 = 1'b0;
  int          strobes2 = 0;
  int          a0_chg2 = 0;

  opll_write_sequencer #(
    .STROBE_W (STROBE_W),
    .ADDR_WAIT(ADDR_WAIT),
    .DATA_WAIT(DATA_WAIT)
  ) dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_phiM_PCEN_n(pcen_n),
    .i_REQ_VALID  (valid),
    .i_REQ_ADDR   (addr),
    .i_REQ_DATA   (data),
    .o_REQ_READY  (ready),
    .o_CS_n       (cs_n),
    .o_WR_n       (wr_n),
    .o_A0         (a0),
    .o_D          (d),
    .o_D_OE       (d_oe),
    .o_BUSY       (busy)
  );

  opll_write_sequencer #(
    .STROBE_W (1),
    .ADDR_WAIT(0),
    .DATA_WAIT(0)
  ) dut2 (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_phiM_PCEN_n(pcen_n),
    .i_REQ_VALID  (valid2),
    .i_REQ_ADDR   (addr2),
    .i_REQ_DATA   (data2),
    .o_REQ_READY  (ready2),
    .o_CS_n       (cs2_n),
    .o_WR_n       (wr2_n),
    .o_A0         (a0_2),
    .o_D          (d2),
    .o_D_OE       (d_oe2),
    .o_BUSY       (busy2)
  );

  initial forever #5 clk = ~clk;

  // One phiM tick every 4th clock unless frozen.
  initial begin
    pcen_n = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      pcen_n = hold || ((cyc % 4) != 0);
    end
  end

  initial forever begin
    @(posedge clk);
    if (!pcen_n) ticks++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Main scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (m_prev_cs && !cs_n) begin
      m_st_tick = ticks;
      m_cur     = {a0, d};
      m_stable  = 1'b1;
      check("strobe_wr_n", 32'(wr_n), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got a0=%0b d=%02h, required no strobe", a0, d);
      end else begin
        m_exp = exp_q.pop_front();
        check("strobe_a0_d", 32'({a0, d}), 32'(m_exp));
      end
      if (a0) check("addr_to_data_gap", ticks - m_addr_tick, STROBE_W + 2 + ADDR_WAIT);
      else m_addr_tick = m_st_tick;
    end else if (!m_prev_cs && !cs_n) begin
      if ({a0, d} !== m_cur || wr_n !== 1'b0) m_stable = 1'b0;
    end else if (!m_prev_cs && cs_n && !abort_ok) begin
      check("strobe_width", ticks - m_st_tick, STROBE_W);
      check("strobe_stable", 32'(m_stable), 32'd1);
    end
    m_prev_cs = cs_n;
  end

  initial forever begin
    @(negedge clk);
    if (m2_prev_cs && !cs2_n) begin
      strobes2++;
      m2_a0 = a0_2;
    end else if (!cs2_n && a0_2 !== m2_a0) begin
      a0_chg2++;
    end
    m2_prev_cs = cs2_n;
  end

  function automatic logic sig(input int k);
    case (k)
      0:       return d_oe;
      1:       return busy;
      2:       return !cs_n && a0;
      3:       return d_oe2;
      4:       return busy2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int k, input logic val, input int budget, input string name);
    int i;
    i = 0;
    while (sig(k) !== val && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (sig(k) !== val) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got no event in %0d clocks, required %0b", name, budget, val);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] dd, output bit waited);
    int i;
    waited = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    data  = dd;
    i = 0;
    while (!ready && i < 5000) begin
      waited = 1'b1;
      @(negedge clk);
      i++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got ready=0, required ready=1");
    end else begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, dd});
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    check({tag, "_wr_n"}, 32'(wr_n), 32'd1);
    check({tag, "_a0"}, 32'(a0), 32'd0);
    check({tag, "_d"}, 32'(d), 32'd0);
    check({tag, "_d_oe"}, 32'(d_oe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    bit          w;
    int          first_low;
    int unsigned p;
    logic [7:0]  ka, kd;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single pair with default timing.
    push(8'h10, 8'hAC, w);
    wait_until(0, 1'b1, 200, "pair_start");
    p = ticks;
    wait_until(1, 1'b0, 2000, "pair_end");
    check("pair_ticks", ticks - p, PAIR_TICKS);
    check("queue_empty_1", 32'(exp_q.size()), 32'd0);

    // Fill the FIFO while the sequencer is busy so no pop can free a slot.
    push(8'h01, 8'hA1, w);
    wait_until(0, 1'b1, 200, "busy_start");
    first_low = -1;
    for (int k = 0; k < 5; k++) begin
      ka = 8'(k + 2);
      kd = 8'(8'hA2 + k);
      push(ka, kd, w);
      if (w && first_low < 0) first_low = k;
    end
    check("ready_low_after_4", 32'(first_low), 32'd4);
    wait_until(1, 1'b0, 6000, "burst_drain");
    check("queue_empty_2", 32'(exp_q.size()), 32'd0);

    // Freeze the tick mid address-WAIT.
    push(8'h20, 8'h55, w);
    wait_until(0, 1'b1, 200, "freeze_start");
    wait_until(0, 1'b0, 200, "freeze_wait");
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 hold = 1'b1;
    repeat (100) @(negedge clk);
    check("freeze_cs_n", 32'(cs_n), 32'd1);
    check("freeze_wr_n", 32'(wr_n), 32'd1);
    check("freeze_a0", 32'(a0), 32'd0);
    check("freeze_d", 32'(d), 32'd0);
    check("freeze_d_oe", 32'(d_oe), 32'd0);
    check("freeze_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    wait_until(1, 1'b0, 2000, "freeze_drain");
    check("queue_empty_3", 32'(exp_q.size()), 32'd0);

    // Reset during the data strobe with two pairs still queued.
    push(8'h30, 8'h11, w);
    push(8'h31, 8'h22, w);
    push(8'h32, 8'h33, w);
    wait_until(2, 1'b1, 400, "data_strobe");
    abort_ok = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    exp_q.delete();
    repeat (200) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    abort_ok = 1'b0;

    // Minimum-timing instance.
    @(negedge clk);
    valid2 = 1'b1;
    addr2  = 8'h40;
    data2  = 8'h66;
    @(posedge clk);
    #1 valid2 = 1'b0;
    wait_until(3, 1'b1, 200, "min_start");
    p = ticks;
    wait_until(4, 1'b0, 400, "min_end");
    check("min_pair_ticks", ticks - p, 32'd8);
    check("min_strobes", 32'(strobes2), 32'd2);
    check("min_a0_stable", 32'(a0_chg2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 ns, required finish");
    $fatal(1, "watchdog");
  end

endmodule
